// File: rtl/pusch_tx_framer_pkg.sv
// Shared constants, tag layout and arithmetic helpers for the PUSCH transmit framer.
// Symbol lengths are derived from the IFFT size plus the cyclic-prefix length of that symbol.
package pusch_tx_pkg;

    localparam int IFFT_SIZE = 2048;
    localparam int N_SYMB    = 14;
    localparam int NCP1      = 160;
    localparam int NCP2      = 144;
    localparam int CALC_W    = 48;
    localparam int OUT_W     = 16;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic       sof;
        logic [3:0] symb;
    } tag_t;

    typedef struct packed {
        logic signed [OUT_W-1:0] val;
        logic                    sat;
    } rs_t;

    function automatic logic [11:0] sym_len(input logic [3:0] symb);
        if (symb == 4'd0 || symb == 4'd7) begin
            return 12'(IFFT_SIZE + NCP1);
        end
        return 12'(IFFT_SIZE + NCP2);
    endfunction

    // Round half-up by adding half an LSB, then arithmetic shift, then clamp to out_w bits.
    function automatic rs_t round_sat(input logic signed [CALC_W-1:0] x,
                                      input int shift, input int out_w);
        logic signed [CALC_W-1:0] one;
        logic signed [CALC_W-1:0] t;
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        rs_t r;
        one = 1;
        t   = x + (one <<< (shift - 1));
        t   = t >>> shift;
        hi  = (one <<< (out_w - 1)) - one;
        lo  = -hi - one;
        r.sat = (t > hi) || (t < lo);
        if (t > hi) begin
            r.val = OUT_W'(hi);
        end else if (t < lo) begin
            r.val = OUT_W'(lo);
        end else begin
            r.val = OUT_W'(t);
        end
        return r;
    endfunction

endpackage

// File: rtl/pusch_tx_framer_if.sv
// Sample-stream bus of the PUSCH framer: CP-extended input side and DAC/fronthaul output side.
interface pusch_tx_framer_if #(
    parameter int WIDTH     = 26,
    parameter int OUT_WIDTH = 16
);
    logic                        in_valid;
    logic                        in_sof;
    logic                        in_ready;
    logic signed [WIDTH-1:0]     data_in_r;
    logic signed [WIDTH-1:0]     data_in_i;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [OUT_WIDTH-1:0] data_out_r;
    logic signed [OUT_WIDTH-1:0] data_out_i;
    logic                        out_sop;
    logic                        out_eop;
    logic                        out_sof;
    logic [3:0]                  symb_idx;
    logic                        sat_flag;
    logic                        len_err;

    modport master (
        output in_valid, in_sof, data_in_r, data_in_i, out_ready,
        input  in_ready, out_valid, data_out_r, data_out_i,
               out_sop, out_eop, out_sof, symb_idx, sat_flag, len_err
    );

    modport slave (
        input  in_valid, in_sof, data_in_r, data_in_i, out_ready,
        output in_ready, out_valid, data_out_r, data_out_i,
               out_sop, out_eop, out_sof, symb_idx, sat_flag, len_err
    );
endinterface

// File: rtl/pusch_tx_framer_sync_fifo.sv
// Show-ahead synchronous FIFO; head entry is always visible on rdata while not empty.
module sync_fifo #(
    parameter int W     = 39,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/pusch_tx_framer.sv
// PUSCH transmit framer: scales CP-extended I/Q to DAC width, tags symbol/subframe
// boundaries and buffers the tagged samples through a small output FIFO.
module pusch_tx_framer
    import pusch_tx_pkg::*;
#(
    parameter int WIDTH      = 26,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 10,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    pusch_tx_framer_if.slave  bus
);
    localparam int TAG_W = $bits(tag_t);
    localparam int FW    = 2*OUT_WIDTH + TAG_W;

    typedef enum logic {WAIT_SOF, RUN} state_t;

    state_t                    state;
    logic [11:0]               samp_cnt;
    logic [3:0]                symb_cnt;
    logic                      sat_q;
    logic                      len_err_q;

    logic                      accept;
    logic                      resync;
    logic                      push;
    logic [11:0]               cur_samp;
    logic [3:0]                cur_symb;
    tag_t                      tag;
    tag_t                      head_tag;
    rs_t                       rs_r;
    rs_t                       rs_i;
    logic [FW-1:0]             wdata;
    logic [FW-1:0]             rdata;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign accept   = bus.in_valid & ~fifo_full;
    assign resync   = bus.in_sof;
    assign push     = accept & ((state == RUN) | bus.in_sof);
    assign cur_samp = resync ? 12'd0 : samp_cnt;
    assign cur_symb = resync ? 4'd0  : symb_cnt;

    always_comb begin
        tag      = '0;
        tag.sop  = (cur_samp == 12'd0);
        tag.eop  = (cur_samp == sym_len(cur_symb) - 12'd1);
        tag.sof  = tag.sop & (cur_symb == 4'd0);
        tag.symb = cur_symb;
    end

    assign rs_r  = round_sat(CALC_W'(bus.data_in_r), SHIFT, OUT_WIDTH);
    assign rs_i  = round_sat(CALC_W'(bus.data_in_i), SHIFT, OUT_WIDTH);
    assign wdata = {OUT_WIDTH'(rs_r.val), OUT_WIDTH'(rs_i.val), tag};

    // Framing FSM: counters track the position of the sample being written this cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= WAIT_SOF;
            samp_cnt  <= '0;
            symb_cnt  <= '0;
            sat_q     <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= accept & bus.in_sof & (state == RUN) &
                         ((samp_cnt != 12'd0) | (symb_cnt != 4'd0));
            if (push) begin
                state <= RUN;
                sat_q <= sat_q | rs_r.sat | rs_i.sat;
                if (tag.eop) begin
                    samp_cnt <= '0;
                    symb_cnt <= (cur_symb == 4'(N_SYMB-1)) ? 4'd0 : cur_symb + 4'd1;
                end else begin
                    samp_cnt <= cur_samp + 12'd1;
                    symb_cnt <= cur_symb;
                end
            end
        end
    end

    sync_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (bus.out_valid & bus.out_ready),
        .wdata (wdata),
        .rdata (rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_tag       = fifo_empty ? '0 : rdata[TAG_W-1:0];
    assign bus.in_ready   = ~fifo_full;
    assign bus.out_valid  = (fifo_count != '0);
    assign bus.data_out_r = fifo_empty ? '0 : rdata[FW-1 -: OUT_WIDTH];
    assign bus.data_out_i = fifo_empty ? '0 : rdata[FW-OUT_WIDTH-1 -: OUT_WIDTH];
    assign bus.out_sop    = head_tag.sop;
    assign bus.out_eop    = head_tag.eop;
    assign bus.out_sof    = head_tag.sof;
    assign bus.symb_idx   = head_tag.symb;
    assign bus.sat_flag   = sat_q;
    assign bus.len_err    = len_err_q;
endmodule
